// File: rtl/iterative_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : iterative_shifter_if
// Brief    : Start/Busy/Done request-result bundle for the iterative shifter.
// Revision : 1.0
// ============================================================================
interface iterative_shifter_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] shift_amount;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output mode,
        output a,
        output b,
        output shift_amount,
        input  result,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  mode,
        input  a,
        input  b,
        input  shift_amount,
        output result,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/iterative_shifter.sv
`default_nettype none
// ============================================================================
// Module   : iterative_shifter
// Brief    : Multi-cycle SLL/SRL/SRA/ROL shifter, up to STEP bits per clock.
// Revision : 1.0
// ============================================================================
module iterative_shifter #(
    parameter int WIDTH = 24,
    parameter int STEP  = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    iterative_shifter_if.slave  bus
);
    localparam int c_cnt_w = $clog2(WIDTH + 1);

    localparam logic [1:0] c_mode_sll = 2'b00;
    localparam logic [1:0] c_mode_srl = 2'b01;
    localparam logic [1:0] c_mode_sra = 2'b10;
    localparam logic [1:0] c_mode_rol = 2'b11;

    localparam logic [WIDTH-1:0]   c_width_v   = WIDTH'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_width_cnt = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_step_cnt  = c_cnt_w'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         mode_q, mode_d;
    logic [c_cnt_w-1:0] remaining_q, remaining_d;
    logic               fill_q, fill_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   w_eff;
    logic               w_out_of_range;
    logic [WIDTH-1:0]   w_rol_n;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w-1:0] w_step_amt;
    logic [2*WIDTH-1:0] w_right_ext;
    logic [2*WIDTH-1:0] w_rot_ext;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_accept;

    // Amount arithmetic wraps at WIDTH bits; the carry out is intentionally lost.
    always_comb begin
        w_eff          = bus.b + bus.shift_amount;
        w_out_of_range = (w_eff >= c_width_v);
        w_rol_n        = w_eff % c_width_v;
        if (bus.mode == c_mode_rol) begin
            w_count = c_cnt_w'(w_rol_n);
        end else if (w_out_of_range) begin
            w_count = c_width_cnt;
        end else begin
            w_count = c_cnt_w'(w_eff);
        end
    end

    // fill_q already folds in the mode, so SRL and SRA share the right path.
    always_comb begin
        w_step_amt  = (remaining_q < c_step_cnt) ? remaining_q : c_step_cnt;
        w_right_ext = {{WIDTH{fill_q}}, result_q} >> w_step_amt;
        w_rot_ext   = {result_q, result_q} << w_step_amt;
        case (mode_q)
            c_mode_sll: w_shifted = result_q << w_step_amt;
            c_mode_srl: w_shifted = w_right_ext[WIDTH-1:0];
            c_mode_sra: w_shifted = w_right_ext[WIDTH-1:0];
            default:    w_shifted = w_rot_ext[2*WIDTH-1:WIDTH];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        w_accept    = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    result_d    = bus.a;
                    mode_d      = bus.mode;
                    remaining_d = w_count;
                    fill_d      = (bus.mode == c_mode_sra) && bus.a[WIDTH-1];
                    state_d     = ST_SHIFT;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (remaining_q != '0) begin
                    result_d    = w_shifted;
                    remaining_d = remaining_q - w_step_amt;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            mode_q      <= c_mode_sll;
            remaining_q <= '0;
            fill_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_iterative_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_shifter
// Brief    : Directed scoreboard bench for iterative_shifter (STEP=1 and STEP=4).
// Revision : 1.0
// ============================================================================
module tb_iterative_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iterative_shifter_if #(.WIDTH(24)) bus1 ();
    iterative_shifter_if #(.WIDTH(24)) bus4 ();

    iterative_shifter #(.WIDTH(24), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    iterative_shifter #(.WIDTH(24), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          t_start  = 0;
    logic [23:0] sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: closed-form shift of the whole operation.
    function automatic logic [23:0] model(input logic [1:0] m, input logic [23:0] a,
                                          input logic [23:0] b, input logic [23:0] sa);
        logic [23:0] eff;
        int k;
        eff = b + sa;
        case (m)
            2'b00: return (eff >= 24) ? 24'h0 : (a << eff);
            2'b01: return (eff >= 24) ? 24'h0 : (a >> eff);
            2'b10: return (eff >= 24) ? {24{a[23]}} : 24'($signed(a) >>> eff);
            default: begin
                k = int'(eff % 24);
                return (k == 0) ? a : ((a << k) | (a >> (24 - k)));
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] m, input logic [23:0] b,
                                     input logic [23:0] sa, input int step);
        logic [23:0] eff;
        int n;
        eff = b + sa;
        if (m == 2'b11) n = int'(eff % 24);
        else            n = (eff >= 24) ? 24 : int'(eff);
        return 2 + (n + step - 1) / step;
    endfunction

    task automatic start_op(input string tag, input logic [1:0] m, input logic [23:0] a,
                            input logic [23:0] b, input logic [23:0] sa, input logic [23:0] exp);
        bus1.mode = m; bus1.a = a; bus1.b = b; bus1.shift_amount = sa;
        bus1.start = 1'b1;
        sb_q.push_back(exp);
        t_start = cyc;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        bus1.a = ~a; bus1.b = 24'($urandom); bus1.shift_amount = 24'($urandom); bus1.mode = ~m;
        check({tag, "_busy_after_accept"}, {31'd0, bus1.busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int entry;
        int busy_cycles;
        int guard;
        logic [23:0] exp;
        entry = cyc - t_start;
        busy_cycles = 0;
        guard = 0;
        while (bus1.done !== 1'b1 && guard < 200) begin
            if (bus1.busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_latency"}, cyc - t_start, exp_lat);
        check({tag, "_busy_cycles"}, busy_cycles, exp_lat - entry);
        check({tag, "_busy_low_at_done"}, {31'd0, bus1.busy}, 32'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_result"}, {8'd0, bus1.result}, {8'd0, exp});
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [23:0] a,
                          input logic [23:0] b, input logic [23:0] sa,
                          input logic [23:0] exp, input int exp_lat);
        start_op(tag, m, a, b, sa, exp);
        wait_done(tag, exp_lat);
        @(posedge clk); #1;
        check({tag, "_idle_done_low"}, {30'd0, bus1.busy, bus1.done}, 32'd0);
        check({tag, "_idle_hold"}, {8'd0, bus1.result}, {8'd0, exp});
    endtask

    task automatic run4(input string tag, input logic [1:0] m, input logic [23:0] a,
                        input logic [23:0] b, input logic [23:0] sa,
                        input logic [23:0] exp, input int exp_lat);
        int t0;
        int guard;
        bus4.mode = m; bus4.a = a; bus4.b = b; bus4.shift_amount = sa;
        bus4.start = 1'b1;
        sb_q.push_back(exp);
        t0 = cyc;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        guard = 0;
        while (bus4.done !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_latency"}, cyc - t0, exp_lat);
        check({tag, "_result"}, {8'd0, bus4.result}, {8'd0, sb_q.pop_front()});
        @(posedge clk); #1;
    endtask

    initial begin
        bus1.start = 1'b0; bus1.mode = 2'b00; bus1.a = '0; bus1.b = '0; bus1.shift_amount = '0;
        bus4.start = 1'b0; bus4.mode = 2'b00; bus4.a = '0; bus4.b = '0; bus4.shift_amount = '0;

        // Start asserted during reset must be overridden.
        bus1.start = 1'b1; bus1.a = 24'hABCDEF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus1.start = 1'b0;
        check("reset_result", {8'd0, bus1.result}, 32'd0);
        check("reset_busy_done", {30'd0, bus1.busy, bus1.done}, 32'd0);
        @(posedge clk); #1;

        run_op("sll_basic", 2'b00, 24'h000001, 24'd3, 24'd2, 24'h000020, 7);
        run_op("sra_neg",   2'b10, 24'h800000, 24'd0, 24'd4, 24'hF80000, 6);
        run_op("srl_neg",   2'b01, 24'h800000, 24'd0, 24'd4, 24'h080000, 6);
        run_op("sll_oor",   2'b00, 24'hFFFFFF, 24'd20, 24'd10, 24'h000000, 26);
        run_op("sra_oor",   2'b10, 24'h800000, 24'd20, 24'd10, 24'hFFFFFF, 26);
        run_op("rol_wrap",  2'b11, 24'h800001, 24'd20, 24'd5, 24'h000003, 3);
        run_op("carry",     2'b00, 24'h000001, 24'hFFFFFF, 24'd2, 24'h000002, 3);
        run_op("zero_amt",  2'b00, 24'h123456, 24'd0, 24'd0, 24'h123456, 2);
        run_op("srl_eq_w",  2'b01, 24'hFFFFFF, 24'd12, 24'd12,
               model(2'b01, 24'hFFFFFF, 24'd12, 24'd12), model_lat(2'b01, 24'd12, 24'd12, 1));
        run_op("rol_8",     2'b11, 24'h123456, 24'd5, 24'd3,
               model(2'b11, 24'h123456, 24'd5, 24'd3), model_lat(2'b11, 24'd5, 24'd3, 1));
        run_op("rol_24",    2'b11, 24'h5A5A0F, 24'd24, 24'd0,
               model(2'b11, 24'h5A5A0F, 24'd24, 24'd0), model_lat(2'b11, 24'd24, 24'd0, 1));
        run_op("sra_pos",   2'b10, 24'h400000, 24'd1, 24'd2,
               model(2'b10, 24'h400000, 24'd1, 24'd2), model_lat(2'b10, 24'd1, 24'd2, 1));
        run_op("sll_23",    2'b00, 24'hABCDEF, 24'd20, 24'd3,
               model(2'b00, 24'hABCDEF, 24'd20, 24'd3), model_lat(2'b00, 24'd20, 24'd3, 1));

        // Start pulsed at t+3 during an operation is ignored.
        start_op("mid_start", 2'b00, 24'h000001, 24'd3, 24'd2, 24'h000020);
        @(posedge clk); #1;
        bus1.start = 1'b1; bus1.a = 24'hFFFFFF; bus1.mode = 2'b01;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        wait_done("mid_start", 7);

        // Start coincident with Done is accepted back-to-back.
        start_op("b2b", 2'b01, 24'hF00000, 24'd2, 24'd2,
                 model(2'b01, 24'hF00000, 24'd2, 24'd2));
        wait_done("b2b", model_lat(2'b01, 24'd2, 24'd2, 1));
        @(posedge clk); #1;

        // Reset at t+3 aborts the operation.
        start_op("abort", 2'b00, 24'h000001, 24'd3, 24'd2, 24'h000020);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_back());
        check("abort_result", {8'd0, bus1.result}, 32'd0);
        check("abort_busy_done", {30'd0, bus1.busy, bus1.done}, 32'd0);
        @(posedge clk); #1;
        check("abort_stays_idle", {30'd0, bus1.busy, bus1.done}, 32'd0);
        run_op("after_abort", 2'b00, 24'h000001, 24'd3, 24'd2, 24'h000020, 7);

        // STEP=4 instance.
        run4("s4_sll10", 2'b00, 24'h000001, 24'd4, 24'd6, 24'h000400, 5);
        run4("s4_sra_oor", 2'b10, 24'h800000, 24'd20, 24'd10, 24'hFFFFFF, 8);
        run4("s4_rol25", 2'b11, 24'h800001, 24'd20, 24'd5, 24'h000003, 3);
        run4("s4_srl7", 2'b01, 24'hF00000, 24'd3, 24'd4,
             model(2'b01, 24'hF00000, 24'd3, 24'd4), model_lat(2'b01, 24'd3, 24'd4, 4));
        run4("s4_zero", 2'b10, 24'h876543, 24'd0, 24'd0, 24'h876543, 2);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
